div_scheduler: RTL and testbench

DIV_SCHEDULER -- requirements
Module: div_scheduler

---
 rtl/div_scheduler.sv | 175 +++++++++++++++++
 tb/tb_div_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_scheduler.sv
// div_scheduler
//   Arbitrates N_REQ requesters onto one shared external divider. A request
//   is granted round-robin, forwarded to the divider with a one-cycle start
//   pulse, and its quotient is returned together with the requester index.
//   If the denominator is zero, or the divider does not finish within
//   TIMEOUT cycles, the block returns a saturated quotient with the error
//   flag set.
//
// Ports
//   clk, reset                       clock, asynchronous active-high reset
//   req_valid/req_num/req_den        per-requester request (packed WIDTH lanes)
//   req_ready                        one-hot accept strobe (IDLE grant cycle only)
//   resp_valid/resp_ready            result handshake
//   resp_id/resp_quot/resp_err       result payload
//   div_start                        one-cycle start pulse to the divider
//   div_numerator/div_denominator    divider operands
//   div_quotient/div_done            divider result and completion
module div_scheduler #(
  parameter int WIDTH   = 16,
  parameter int FRAC_SZ = 12,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_num,
  input  logic [N_REQ*WIDTH-1:0]     req_den,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(N_REQ)-1:0]   resp_id,
  output logic [WIDTH-1:0]           resp_quot,
  output logic                       resp_err,
  output logic                       div_start,
  output logic [WIDTH-1:0]           div_numerator,
  output logic [WIDTH-1:0]           div_denominator,
  input  logic [WIDTH-1:0]           div_quotient,
  input  logic                       div_done
);

  localparam int IDW  = $clog2(N_REQ);
  localparam int CNTW = $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  // FRAC_SZ only describes the fixed-point format seen by the divider.
  if (FRAC_SZ >= WIDTH || N_REQ < 2 || N_REQ > 8) begin : g_param_check
    $error("div_scheduler: FRAC_SZ must be < WIDTH and N_REQ in 2..8");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [IDW-1:0]    r_ptr;
  logic [CNTW-1:0]   r_cnt;
  logic              r_resp_valid;
  logic [IDW-1:0]    r_resp_id;
  logic [WIDTH-1:0]  r_resp_quot;
  logic              r_resp_err;
  logic              r_div_start;
  logic [WIDTH-1:0]  r_div_num;
  logic [WIDTH-1:0]  r_div_den;

  logic              w_gnt_vld;
  logic [IDW-1:0]    w_gnt_id;
  logic [IDW-1:0]    w_cand;
  logic [WIDTH-1:0]  w_sel_num;
  logic [WIDTH-1:0]  w_sel_den;

  // Saturated result: most positive for num >= 0, most negative otherwise.
  function automatic logic [WIDTH-1:0] f_sat(input logic [WIDTH-1:0] num);
    f_sat = num[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // Round-robin search: first valid requester at or after r_ptr (wrapping).
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_cand    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_cand = IDW'((32'(r_ptr) + k) % 32'(N_REQ));
      if (!w_gnt_vld && req_valid[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_cand;
      end
    end
    w_sel_num = req_num[int'(w_gnt_id)*WIDTH +: WIDTH];
    w_sel_den = req_den[int'(w_gnt_id)*WIDTH +: WIDTH];
  end

  // Accept strobe is combinational so it coincides with the latching edge;
  // reset gates it so it clears asynchronously like the registered outputs.
  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && w_gnt_vld && !reset) begin
      req_ready[w_gnt_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_quot  <= '0;
      r_resp_err   <= 1'b0;
      r_div_start  <= 1'b0;
      r_div_num    <= '0;
      r_div_den    <= '0;
    end else begin
      r_div_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_resp_id <= w_gnt_id;
            r_div_num <= w_sel_num;
            r_div_den <= w_sel_den;
            if (w_sel_den == '0) begin
              r_resp_valid <= 1'b1;
              r_resp_quot  <= f_sat(w_sel_num);
              r_resp_err   <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_div_start <= 1'b1;
              r_state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (div_done) begin
            r_resp_valid <= 1'b1;
            r_resp_quot  <= div_quotient;
            r_resp_err   <= 1'b0;
            r_state      <= S_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_resp_valid <= 1'b1;
            r_resp_quot  <= f_sat(r_div_num);
            r_resp_err   <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_ptr        <= (r_resp_id == IDW'(N_REQ - 1)) ? '0 : r_resp_id + 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid      = r_resp_valid;
  assign resp_id         = r_resp_id;
  assign resp_quot       = r_resp_quot;
  assign resp_err        = r_resp_err;
  assign div_start       = r_div_start;
  assign div_numerator   = r_div_num;
  assign div_denominator = r_div_den;

endmodule

// File: tb/tb_div_scheduler.sv
// tb_div_scheduler
//   Scoreboard bench for div_scheduler. Requesters, a behavioural divider
//   and a response monitor run as concurrent threads; the monitor predicts
//   grants and responses from the round-robin / saturation / timeout rules.
module tb_div_scheduler;

  localparam int W   = 16;
  localparam int FR  = 12;
  localparam int N   = 4;
  localparam int TO  = 64;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_num = '0;
  logic [N*W-1:0]   req_den = '0;
  logic [N-1:0]     req_ready;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic [IDW-1:0]   resp_id;
  logic [W-1:0]     resp_quot;
  logic             resp_err;
  logic             div_start;
  logic [W-1:0]     div_numerator;
  logic [W-1:0]     div_denominator;
  logic [W-1:0]     div_quotient = '0;
  logic             div_done = 1'b0;

  div_scheduler #(.WIDTH(W), .FRAC_SZ(FR), .N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_num(req_num), .req_den(req_den),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_quot(resp_quot), .resp_err(resp_err),
    .div_start(div_start), .div_numerator(div_numerator),
    .div_denominator(div_denominator),
    .div_quotient(div_quotient), .div_done(div_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [W-1:0] num;
    logic [W-1:0] den;
    int         gcyc;
  } exp_t;

  exp_t         sb[$];
  int           grant_log[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           m_ptr = 0;
  bit           stub = 0;
  bit           spurious_en = 1;
  bit           rand_en = 0;
  bit           rr_rand = 0;
  int           rr_hold = 0;
  logic [N-1:0] pend = '0;
  logic [N-1:0] accepted = '0;
  logic [W-1:0] pn [N];
  logic [W-1:0] pd [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Q4.12 divide as a real divider would produce it, truncated toward zero.
  function automatic logic [W-1:0] ref_div(input logic [W-1:0] n, input logic [W-1:0] d);
    longint q;
    q = (longint'($signed(n)) * (longint'(1) << FR)) / longint'($signed(d));
    return q[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_sat(input logic [W-1:0] n);
    return ($signed(n) >= 0) ? 16'h7FFF : 16'h8000;
  endfunction

  task automatic monitor_loop();
    logic [W-1:0]   s_quot;
    logic [IDW-1:0] s_id;
    logic           s_err;
    logic           rv_prev;
    logic [N-1:0]   exp_rdy;
    logic [W-1:0]   eq;
    logic           ee;
    int             done_cyc;
    int             exp_rise;
    int             g;
    bit             busy_now;
    exp_t           e;
    rv_prev  = 1'b0;
    done_cyc = -1;
    s_quot = '0; s_id = '0; s_err = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        sb.delete();
        grant_log.delete();
        m_ptr    = 0;
        rv_prev  = 1'b0;
        done_cyc = -1;
        continue;
      end
      busy_now = (sb.size() != 0);
      accepted = accepted | req_ready;

      // Grant prediction: only when nothing is outstanding.
      exp_rdy = '0;
      g = -1;
      if (!busy_now && req_valid != '0) begin
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        exp_rdy[g] = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));

      if (busy_now) begin
        e = sb[0];
        chk("div_start", 32'(div_start),
            32'(e.den != '0 && cyc == e.gcyc + 1));
        if (e.den != '0 && !resp_valid)
          chk("div_operands", {div_numerator, div_denominator}, {e.num, e.den});
        if (e.den != '0 && done_cyc < 0 && div_done &&
            cyc > e.gcyc + 1 && cyc <= e.gcyc + 1 + TO)
          done_cyc = cyc;
      end else begin
        chk("div_start_idle", 32'(div_start), 32'd0);
      end

      if (resp_valid && !rv_prev) begin
        if (!busy_now) begin
          chk("stale_resp", 32'(resp_valid), 32'd0);
        end else begin
          e = sb[0];
          if (e.den == '0)      exp_rise = e.gcyc + 1;
          else if (done_cyc >= 0) exp_rise = done_cyc + 1;
          else                  exp_rise = e.gcyc + 2 + TO;
          chk("resp_latency", cyc, exp_rise);
        end
        s_quot = resp_quot; s_id = resp_id; s_err = resp_err;
      end else if (resp_valid) begin
        chk("resp_hold", 32'({resp_err, resp_id, resp_quot}), 32'({s_err, s_id, s_quot}));
      end

      if (resp_valid && resp_ready && busy_now) begin
        e = sb.pop_front();
        if (e.den == '0 || done_cyc < 0) begin
          eq = ref_sat(e.num); ee = 1'b1;
        end else begin
          eq = ref_div(e.num, e.den); ee = 1'b0;
        end
        chk("resp_id", 32'(resp_id), e.id);
        chk("resp_quot", 32'(resp_quot), 32'(eq));
        chk("resp_err", 32'(resp_err), 32'(ee));
        m_ptr    = (e.id + 1) % N;
        done_cyc = -1;
      end
      rv_prev = resp_valid && !resp_ready;

      if (g >= 0) begin
        e.id   = g;
        e.num  = req_num[g*W +: W];
        e.den  = req_den[g*W +: W];
        e.gcyc = cyc;
        sb.push_back(e);
        grant_log.push_back(g);
        done_cyc = -1;
      end
    end
  endtask

  task automatic requester_loop();
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (accepted[i]) begin
          accepted[i]  = 1'b0;
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i]) begin
          if (pend[i]) begin
            req_num[i*W +: W] = pn[i];
            req_den[i*W +: W] = pd[i];
            req_valid[i] = 1'b1;
            pend[i] = 1'b0;
          end else if (rand_en && $urandom_range(0, 3) == 0) begin
            req_num[i*W +: W] = W'($urandom);
            req_den[i*W +: W] = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 65535));
            req_valid[i] = 1'b1;
          end
        end
      end
      if (rr_hold > 0) begin
        resp_ready = 1'b0;
        if (resp_valid) rr_hold--;
      end else begin
        resp_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  endtask

  task automatic divider_loop();
    bit           busy;
    int           cnt;
    logic [W-1:0] ln;
    logic [W-1:0] ld;
    busy = 0; cnt = 0; ln = '0; ld = '0;
    forever begin
      @(posedge clk); #1;
      div_done = 1'b0;
      if (reset) begin
        busy = 0;
        continue;
      end
      if (busy && !stub) begin
        if (cnt == 0) begin
          div_done     = 1'b1;
          div_quotient = ref_div(ln, ld);
          busy         = 0;
        end else begin
          cnt--;
        end
      end else if (!busy && spurious_en && $urandom_range(0, 5) == 0) begin
        div_done     = 1'b1;
        div_quotient = W'($urandom);
      end
      if (div_start) begin
        busy = 1;
        cnt  = $urandom_range(0, 4);
        ln   = div_numerator;
        ld   = div_denominator;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_quot"}, 32'(resp_quot), 32'd0);
    chk({tag, "_resp_id"}, 32'(resp_id), 32'd0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_div_start"}, 32'(div_start), 32'd0);
    chk({tag, "_div_num"}, 32'(div_numerator), 32'd0);
    chk({tag, "_div_den"}, 32'(div_denominator), 32'd0);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || req_valid != '0 || pend != '0 || resp_valid) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({"drain_", name}, 32'(n < budget), 32'd1);
    repeat (2) @(posedge clk);
  endtask

  task automatic request(input int i, input logic [W-1:0] n, input logic [W-1:0] d);
    pn[i]   = n;
    pd[i]   = d;
    pend[i] = 1'b1;
  endtask

  task automatic pulse_reset(input int hold);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_zero("rst");
    repeat (hold) @(posedge clk);
    #3 reset = 1'b0;
  endtask

  initial begin
    int exp_order [5];
    int n;
    exp_order = '{0, 1, 2, 3, 0};
    fork
      monitor_loop();
      requester_loop();
      divider_loop();
      begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
      end
    join_none

    // Power-on reset.
    repeat (3) @(posedge clk);
    #1 check_zero("por");
    #2 reset = 1'b0;

    // Single nominal division: 1.0 / 0.5 = 2.0.
    request(0, 16'd4096, 16'd2048);
    drain("basic", 200);

    // Round-robin from a fresh pointer with all requesters active.
    pulse_reset(2);
    request(0, 16'd4096, 16'd1024);
    request(1, 16'hF000, 16'd3000);
    request(2, 16'd1234, 16'hFF00);
    request(3, 16'h7FFF, 16'd1);
    repeat (2) @(posedge clk);
    request(0, 16'd100, 16'd7);
    drain("rr", 400);
    for (int k = 0; k < 5; k++)
      chk("rr_order", (k < grant_log.size()) ? grant_log[k] : -1, exp_order[k]);

    // Divide by zero, both signs.
    request(2, 16'd4096, 16'd0);
    drain("dz_pos", 200);
    request(2, 16'hF000, 16'd0);
    drain("dz_neg", 200);

    // Divider never answers: timeout path.
    stub = 1;
    request(1, 16'hF800, 16'd4096);
    drain("timeout", 300);
    stub = 0;

    // Consumer stalls for 10 cycles while another requester waits.
    rr_hold = 10;
    request(0, 16'd3000, 16'd5);
    request(3, 16'hC000, 16'd0);
    drain("stall", 400);

    // Reset while the divider is busy: pointer ends at 3 first, then the
    // in-flight request is dropped and arbitration restarts from 0.
    request(2, 16'd500, 16'd7);
    drain("pre_wait_rst", 200);
    stub = 1;
    request(2, 16'd1000, 16'd3);
    n = 0;
    while (sb.size() == 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("wait_rst_grant", 32'(n < 50), 32'd1);
    request(1, 16'd2000, 16'd9);
    request(3, 16'd3000, 16'd11);
    repeat (4) @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    #1 check_zero("wait_rst");
    stub = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    drain("post_wait_rst", 400);
    chk("post_rst_first_grant", (grant_log.size() != 0) ? grant_log[0] : -1, 1);

    // Randomized traffic with random back-pressure and spurious div_done.
    rand_en = 1;
    rr_rand = 1;
    repeat (3000) @(posedge clk);
    rand_en = 0;
    rr_rand = 0;
    drain("random", 3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
